udp_fragment_slot_manager: RTL and testbench

Owns the pool of IPv4 fragment reassembly slots on the UDP receive path. It sits between the UDP receive handler and the per-slot fragment FIFOs. It allocates empty slots to new packet IDs and publishes slot empty/packet-ID status to the handler. It also ages each slot against an inactivity timeout and retires slots on completion, drain release or timeout flush.

---
 rtl/udp_pkg.sv | 20 ++
 rtl/udp_fragment_slot_manager_if.sv | 30 +++
 rtl/udp_fragment_slot.sv | 90 +++++++++
 rtl/udp_fragment_slot_manager.sv | 115 +++++++++++
 tb/tb_udp_fragment_slot_manager.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/udp_pkg.sv
// Shared definitions for the UDP fragment reassembly slot manager.
//   fragment_slot_state_type : per-slot lifecycle state
//   DEFAULT_SLOT_TIMEOUT     : idle cycles before a filling slot is flushed
//   slot_index_width()       : width of a slot index for a given slot count
package udp_pkg;

  typedef enum logic [1:0] {
    S_EMPTY    = 2'd0,
    S_FILLING  = 2'd1,
    S_COMPLETE = 2'd2,
    S_FLUSH    = 2'd3
  } fragment_slot_state_type;

  localparam logic [15:0] DEFAULT_SLOT_TIMEOUT = 16'h0FFF;

  function automatic int slot_index_width(input int slots);
    return (slots > 1) ? $clog2(slots) : 1;
  endfunction

endpackage

// File: rtl/udp_fragment_slot_manager_if.sv
// Allocation handshake between the UDP receive handler (master) and the
// slot manager (slave).
//   allocate_request   : level, held by the requester until grant/reject
//   allocate_packet_id : IPv4 identification to bind
//   allocate_grant     : one-cycle pulse, slot bound
//   allocate_reject    : one-cycle pulse, no slot free
//   allocate_slot      : bound slot index, valid with grant
interface udp_fragment_slot_manager_if
  import udp_pkg::*;
#(
  parameter int FRAGMENT_SLOTS = 2
);
  localparam int SLOT_W = slot_index_width(FRAGMENT_SLOTS);

  logic              allocate_request;
  logic [15:0]       allocate_packet_id;
  logic              allocate_grant;
  logic              allocate_reject;
  logic [SLOT_W-1:0] allocate_slot;

  modport master (
    output allocate_request, allocate_packet_id,
    input  allocate_grant, allocate_reject, allocate_slot
  );

  modport slave (
    input  allocate_request, allocate_packet_id,
    output allocate_grant, allocate_reject, allocate_slot
  );
endinterface

// File: rtl/udp_fragment_slot.sv
// One reassembly slot: lifecycle FSM, inactivity age counter and bound
// packet-ID register.
//   grant / grant_packet_id : bind this slot (only acted on when empty)
//   push_data_valid/last    : handler write / final-fragment strobes
//   drain_release           : downstream drain-done pulse
//                             ("release" itself is a reserved word)
//   slot_empty, packet_id, complete, flush : registered status
//   flush_start             : combinational, high on the FILLING->FLUSH edge
module udp_fragment_slot
  import udp_pkg::*;
#(
  parameter logic [15:0] SLOT_TIMEOUT = DEFAULT_SLOT_TIMEOUT
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        grant,
  input  logic [15:0] grant_packet_id,
  input  logic        push_data_valid,
  input  logic        push_data_last,
  input  logic        drain_release,
  output logic        slot_empty,
  output logic [15:0] packet_id,
  output logic        complete,
  output logic        flush,
  output logic        flush_start
);

  fragment_slot_state_type state, state_n;
  logic [15:0] age, age_n;
  logic [15:0] id_q, id_n;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_EMPTY;
      age   <= '0;
      id_q  <= '0;
    end else begin
      state <= state_n;
      age   <= age_n;
      id_q  <= id_n;
    end
  end

  always_comb begin
    state_n     = state;
    age_n       = age;
    id_n        = id_q;
    flush_start = 1'b0;
    case (state)
      S_EMPTY: begin
        if (grant) begin
          state_n = S_FILLING;
          age_n   = '0;
          id_n    = grant_packet_id;
        end
      end
      S_FILLING: begin
        if (push_data_valid)          age_n = '0;
        else if (age < SLOT_TIMEOUT)  age_n = age + 16'd1;
        // a final fragment arriving on the timeout cycle still completes
        if (push_data_last) begin
          state_n = S_COMPLETE;
        end else if (age == SLOT_TIMEOUT) begin
          state_n     = S_FLUSH;
          flush_start = 1'b1;
        end
      end
      S_COMPLETE: begin
        if (drain_release) begin
          state_n = S_EMPTY;
          id_n    = '0;
        end
      end
      S_FLUSH: begin
        state_n = S_EMPTY;
        id_n    = '0;
      end
      default: begin
        state_n = S_EMPTY;
        id_n    = '0;
      end
    endcase
  end

  assign slot_empty = (state == S_EMPTY);
  assign complete   = (state == S_COMPLETE);
  assign flush      = (state == S_FLUSH);
  assign packet_id  = id_q;

endmodule

// File: rtl/udp_fragment_slot_manager.sv
// Pool of IPv4 fragment reassembly slots. Round-robin allocation of empty
// slots to new packet IDs, per-slot status, and a saturating count of
// timeout flushes.
//   clock, reset_n            : clock / async active-low reset
//   alloc                     : allocation handshake (slave side)
//   push_data_valid/last      : per-slot handler strobes
//   drain_release             : per-slot drain-done pulse
//   fragment_slot_empty       : 1 = slot free
//   fragment_slot_packet_id   : bound ID per slot, 0 when empty
//   fragment_complete         : slot holds a full packet
//   fragment_flush            : one-cycle FIFO reset pulse per slot
//   flush_count               : saturating timeout-flush count
module udp_fragment_slot_manager
  import udp_pkg::*;
#(
  parameter int          FRAGMENT_SLOTS = 2,
  parameter logic [15:0] SLOT_TIMEOUT   = DEFAULT_SLOT_TIMEOUT
) (
  input  logic                                clock,
  input  logic                                reset_n,
  udp_fragment_slot_manager_if.slave          alloc,
  input  logic [FRAGMENT_SLOTS-1:0]           push_data_valid,
  input  logic [FRAGMENT_SLOTS-1:0]           push_data_last,
  input  logic [FRAGMENT_SLOTS-1:0]           drain_release,
  output logic [FRAGMENT_SLOTS-1:0]           fragment_slot_empty,
  output logic [FRAGMENT_SLOTS-1:0][15:0]     fragment_slot_packet_id,
  output logic [FRAGMENT_SLOTS-1:0]           fragment_complete,
  output logic [FRAGMENT_SLOTS-1:0]           fragment_flush,
  output logic [15:0]                         flush_count
);

  localparam int SLOT_W = slot_index_width(FRAGMENT_SLOTS);
  localparam logic [SLOT_W:0] SLOTS_EXT = (SLOT_W+1)'(FRAGMENT_SLOTS);

  logic              grant_q, reject_q;
  logic [SLOT_W-1:0] slot_q, rr_pointer;
  logic              req_live, found, do_grant, do_reject;
  logic [SLOT_W-1:0] pick;
  logic [SLOT_W:0]   cand_sum;
  logic [FRAGMENT_SLOTS-1:0] slot_grant, flush_start;
  logic [16:0]       fc_sum;

  // A request is only live when no response is on the bus, so a held
  // request yields exactly one grant/reject.
  assign req_live = alloc.allocate_request && !grant_q && !reject_q;

  // Round-robin search starting at rr_pointer, wrapping at FRAGMENT_SLOTS.
  always_comb begin
    found    = 1'b0;
    pick     = '0;
    cand_sum = '0;
    for (int k = 0; k < FRAGMENT_SLOTS; k++) begin
      cand_sum = {1'b0, rr_pointer} + (SLOT_W+1)'(k);
      if (cand_sum >= SLOTS_EXT) cand_sum = cand_sum - SLOTS_EXT;
      if (!found && fragment_slot_empty[cand_sum[SLOT_W-1:0]]) begin
        found = 1'b1;
        pick  = cand_sum[SLOT_W-1:0];
      end
    end
  end

  assign do_grant  = req_live && found;
  assign do_reject = req_live && !found;

  genvar i;
  generate
    for (i = 0; i < FRAGMENT_SLOTS; i++) begin : g_slot
      assign slot_grant[i] = do_grant && (pick == SLOT_W'(i));
      udp_fragment_slot #(.SLOT_TIMEOUT(SLOT_TIMEOUT)) u_slot (
        .clock           (clock),
        .reset_n         (reset_n),
        .grant           (slot_grant[i]),
        .grant_packet_id (alloc.allocate_packet_id),
        .push_data_valid (push_data_valid[i]),
        .push_data_last  (push_data_last[i]),
        .drain_release   (drain_release[i]),
        .slot_empty      (fragment_slot_empty[i]),
        .packet_id       (fragment_slot_packet_id[i]),
        .complete        (fragment_complete[i]),
        .flush           (fragment_flush[i]),
        .flush_start     (flush_start[i])
      );
    end
  endgenerate

  // Several slots may time out together; add them all, then saturate.
  always_comb begin
    fc_sum = {1'b0, flush_count};
    for (int k = 0; k < FRAGMENT_SLOTS; k++)
      fc_sum = fc_sum + 17'(flush_start[k]);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      grant_q     <= 1'b0;
      reject_q    <= 1'b0;
      slot_q      <= '0;
      rr_pointer  <= '0;
      flush_count <= '0;
    end else begin
      grant_q     <= do_grant;
      reject_q    <= do_reject;
      flush_count <= fc_sum[16] ? 16'hFFFF : fc_sum[15:0];
      if (do_grant) begin
        slot_q     <= pick;
        rr_pointer <= (pick == SLOT_W'(FRAGMENT_SLOTS - 1)) ? '0 : pick + 1'b1;
      end
    end
  end

  assign alloc.allocate_grant  = grant_q;
  assign alloc.allocate_reject = reject_q;
  assign alloc.allocate_slot   = slot_q;

endmodule

// File: tb/tb_udp_fragment_slot_manager.sv
module tb_udp_fragment_slot_manager;
  import udp_pkg::*;

  localparam int N = 2;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic [N-1:0] push_data_valid = '0, push_data_last = '0, drain_release = '0;
  logic [N-1:0] fragment_slot_empty, fragment_complete, fragment_flush;
  logic [N-1:0][15:0] fragment_slot_packet_id;
  logic [15:0] flush_count;

  int n_cmp = 0;
  int n_bad = 0;

  udp_fragment_slot_manager_if #(.FRAGMENT_SLOTS(N)) alloc_bus ();

  udp_fragment_slot_manager #(.FRAGMENT_SLOTS(N), .SLOT_TIMEOUT(16'd16)) dut (
    .clock                   (clock),
    .reset_n                 (reset_n),
    .alloc                   (alloc_bus),
    .push_data_valid         (push_data_valid),
    .push_data_last          (push_data_last),
    .drain_release           (drain_release),
    .fragment_slot_empty     (fragment_slot_empty),
    .fragment_slot_packet_id (fragment_slot_packet_id),
    .fragment_complete       (fragment_complete),
    .fragment_flush          (fragment_flush),
    .flush_count             (flush_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        req;
    logic [15:0] id;
    logic [1:0]  valid, last, rel;
    logic        e_grant, e_reject, e_slot;
    logic [1:0]  e_empty, e_complete, e_flush;
    logic [15:0] e_fc, e_id0, e_id1;
  } vec_t;

  vec_t vt[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    alloc_bus.allocate_request = 1'b0;
    push_data_valid = '0;
    push_data_last  = '0;
    drain_release   = '0;
  endtask

  initial begin
    //        req id       valid  last   rel    g  r  s  empty  cmp    fl     fc  id0      id1
    vt[0]  = '{0, 16'h0,    2'b00, 2'b00, 2'b00, 0, 0, 0, 2'b11, 2'b00, 2'b00, 0, 16'h0,    16'h0};
    vt[1]  = '{1, 16'h1234, 2'b00, 2'b00, 2'b00, 1, 0, 0, 2'b10, 2'b00, 2'b00, 0, 16'h1234, 16'h0};
    vt[2]  = '{0, 16'h0,    2'b00, 2'b01, 2'b00, 0, 0, 0, 2'b10, 2'b01, 2'b00, 0, 16'h1234, 16'h0};
    vt[3]  = '{0, 16'h0,    2'b00, 2'b00, 2'b01, 0, 0, 0, 2'b11, 2'b00, 2'b00, 0, 16'h0,    16'h0};
    vt[4]  = '{1, 16'hAAAA, 2'b00, 2'b00, 2'b00, 1, 0, 1, 2'b01, 2'b00, 2'b00, 0, 16'h0,    16'hAAAA};
    vt[5]  = '{1, 16'hAAAA, 2'b00, 2'b00, 2'b00, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0, 16'h0,    16'hAAAA};
    vt[6]  = '{1, 16'hBBBB, 2'b00, 2'b00, 2'b00, 1, 0, 0, 2'b00, 2'b00, 2'b00, 0, 16'hBBBB, 16'hAAAA};
    vt[7]  = '{0, 16'h0,    2'b00, 2'b00, 2'b00, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 16'hBBBB, 16'hAAAA};
    vt[8]  = '{1, 16'hCCCC, 2'b00, 2'b00, 2'b00, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0, 16'hBBBB, 16'hAAAA};
    vt[9]  = '{1, 16'hCCCC, 2'b00, 2'b00, 2'b11, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 16'hBBBB, 16'hAAAA};
    vt[10] = '{0, 16'h0,    2'b00, 2'b11, 2'b00, 0, 0, 0, 2'b00, 2'b11, 2'b00, 0, 16'hBBBB, 16'hAAAA};
    vt[11] = '{0, 16'h0,    2'b00, 2'b00, 2'b11, 0, 0, 0, 2'b11, 2'b00, 2'b00, 0, 16'h0,    16'h0};

    idle();
    alloc_bus.allocate_packet_id = '0;
    repeat (2) @(posedge clock);
    #2 reset_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      alloc_bus.allocate_request   = vt[i].req;
      alloc_bus.allocate_packet_id = vt[i].id;
      push_data_valid = vt[i].valid;
      push_data_last  = vt[i].last;
      drain_release   = vt[i].rel;
      step();
      chk($sformatf("v%0d grant", i), 32'(alloc_bus.allocate_grant), 32'(vt[i].e_grant));
      chk($sformatf("v%0d reject", i), 32'(alloc_bus.allocate_reject), 32'(vt[i].e_reject));
      if (vt[i].e_grant)
        chk($sformatf("v%0d slot", i), 32'(alloc_bus.allocate_slot), 32'(vt[i].e_slot));
      chk($sformatf("v%0d empty", i), 32'(fragment_slot_empty), 32'(vt[i].e_empty));
      chk($sformatf("v%0d complete", i), 32'(fragment_complete), 32'(vt[i].e_complete));
      chk($sformatf("v%0d flush", i), 32'(fragment_flush), 32'(vt[i].e_flush));
      chk($sformatf("v%0d flush_count", i), 32'(flush_count), 32'(vt[i].e_fc));
      chk($sformatf("v%0d id0", i), 32'(fragment_slot_packet_id[0]), 32'(vt[i].e_id0));
      chk($sformatf("v%0d id1", i), 32'(fragment_slot_packet_id[1]), 32'(vt[i].e_id1));
    end
    idle();

    // timeout flush: both empty, pointer at 1 -> slot 1; idle 17 cycles after last valid
    alloc_bus.allocate_request = 1'b1;
    alloc_bus.allocate_packet_id = 16'h5555;
    step();
    chk("toA grant", 32'(alloc_bus.allocate_grant), 32'd1);
    chk("toA slot", 32'(alloc_bus.allocate_slot), 32'd1);
    alloc_bus.allocate_request = 1'b0;
    push_data_valid = 2'b10;
    step();
    push_data_valid = 2'b00;
    for (int k = 1; k <= 16; k++) begin
      step();
      chk($sformatf("toA early flush k=%0d", k), 32'(fragment_flush), 32'd0);
    end
    step();
    chk("toA flush pulse", 32'(fragment_flush), 32'b10);
    chk("toA flush_count", 32'(flush_count), 32'd1);
    chk("toA empty during flush", 32'(fragment_slot_empty), 32'b01);
    step();
    chk("toA flush end", 32'(fragment_flush), 32'd0);
    chk("toA empty after", 32'(fragment_slot_empty), 32'b11);
    chk("toA id cleared", 32'(fragment_slot_packet_id[1]), 32'd0);

    // last arrives on the very cycle age reaches the timeout -> complete
    alloc_bus.allocate_request = 1'b1;
    alloc_bus.allocate_packet_id = 16'h6666;
    step();
    chk("lvt grant", 32'(alloc_bus.allocate_grant), 32'd1);
    chk("lvt slot", 32'(alloc_bus.allocate_slot), 32'd0);
    alloc_bus.allocate_request = 1'b0;
    for (int k = 1; k <= 16; k++) step();
    push_data_last = 2'b01;
    step();
    push_data_last = 2'b00;
    chk("lvt complete", 32'(fragment_complete), 32'b01);
    chk("lvt no flush", 32'(fragment_flush), 32'd0);
    chk("lvt flush_count", 32'(flush_count), 32'd1);
    step();
    chk("lvt no flush later", 32'(fragment_flush), 32'd0);
    drain_release = 2'b01;
    step();
    drain_release = 2'b00;
    chk("lvt released", 32'(fragment_slot_empty), 32'b11);

    // reset mid-fill
    alloc_bus.allocate_request = 1'b1;
    alloc_bus.allocate_packet_id = 16'h7777;
    step();
    chk("rst grant", 32'(alloc_bus.allocate_grant), 32'd1);
    chk("rst slot", 32'(alloc_bus.allocate_slot), 32'd1);
    alloc_bus.allocate_request = 1'b0;
    push_data_valid = 2'b10;
    #2 reset_n = 1'b0;
    #1;
    chk("rst async grant", 32'(alloc_bus.allocate_grant), 32'd0);
    chk("rst async slot", 32'(alloc_bus.allocate_slot), 32'd0);
    chk("rst async empty", 32'(fragment_slot_empty), 32'b11);
    chk("rst async id1", 32'(fragment_slot_packet_id[1]), 32'd0);
    chk("rst async flush_count", 32'(flush_count), 32'd0);
    push_data_valid = 2'b00;
    step();
    chk("rst held flush", 32'(fragment_flush), 32'd0);
    reset_n = 1'b1;
    alloc_bus.allocate_request = 1'b1;
    alloc_bus.allocate_packet_id = 16'h8888;
    step();
    chk("post-rst slot", 32'(alloc_bus.allocate_slot), 32'd0);
    chk("post-rst grant", 32'(alloc_bus.allocate_grant), 32'd1);
    chk("post-rst id0", 32'(fragment_slot_packet_id[0]), 32'h8888);
    idle();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
